// File: rtl/cache_miss_fill.sv
// Miss handler and line-fill engine: fetches a 32B line in 8 beats, writes it to the round-robin
// victim way and returns it on fetchData. Optional miss counter enabled by MISS_CNT_EN.
module cache_miss_fill #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned BEAT_W     = 32,
  parameter int unsigned LINE_BEATS = 8,
  parameter int unsigned TAG_W      = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic [ADDR_W-1:0]            pcOut,
  input  logic                         hit,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_gnt,
  input  logic                         mem_rvalid,
  input  logic [BEAT_W-1:0]            mem_rdata,
  output logic                         stall,
  output logic                         regWrite_set0,
  output logic                         regWrite_set1,
  output logic                         inp_viv,
  output logic [TAG_W-1:0]             in_tag,
  output logic [LINE_BEATS*BEAT_W-1:0] inputData,
  output logic [LINE_BEATS*BEAT_W-1:0] fetchData,
  output logic                         fill_valid,
  output logic [15:0]                  miss_count
);

  localparam int unsigned LineW = LINE_BEATS * BEAT_W;
  localparam int unsigned OffW  = $clog2(LineW / 8);
  localparam int unsigned IdxW  = ADDR_W - TAG_W - OffW;
  localparam int unsigned Sets  = 1 << IdxW;
  localparam int unsigned CntW  = $clog2(LINE_BEATS);

  typedef enum logic [2:0] {StIdle, StReq, StFill, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              victim_q, victim_d;
  logic [Sets-1:0]   vbit_q, vbit_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [LineW-1:0]  buf_q, buf_d;
  logic [LineW-1:0]  line_q, line_d;
  logic              miss_start;
  logic              unused_pc_off;

  assign unused_pc_off = ^pcOut[OffW-1:0];
  assign miss_start    = (state_q == StIdle) && req_valid && !hit;

  always_comb begin
    state_d       = state_q;
    line_addr_d   = line_addr_q;
    idx_d         = idx_q;
    tag_d         = tag_q;
    victim_d      = victim_q;
    vbit_d        = vbit_q;
    cnt_d         = cnt_q;
    buf_d         = buf_q;
    line_d        = line_q;
    stall         = 1'b0;
    mem_req       = 1'b0;
    mem_addr      = '0;
    regWrite_set0 = 1'b0;
    regWrite_set1 = 1'b0;
    inp_viv       = 1'b0;
    in_tag        = '0;
    inputData     = line_q;
    fetchData     = line_q;
    fill_valid    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (miss_start) begin
          line_addr_d = {pcOut[ADDR_W-1:OffW], {OffW{1'b0}}};
          idx_d       = pcOut[OffW +: IdxW];
          tag_d       = pcOut[ADDR_W-1 -: TAG_W];
          victim_d    = vbit_q[pcOut[OffW +: IdxW]];
          cnt_d       = '0;
          state_d     = StReq;
        end
      end
      StReq: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = line_addr_q;
        if (mem_gnt) state_d = StFill;
      end
      StFill: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          for (int b = 0; b < LINE_BEATS; b++) begin
            if (cnt_q == CntW'(b)) buf_d[b*BEAT_W +: BEAT_W] = mem_rdata;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(LINE_BEATS - 1)) state_d = StWrite;
        end
      end
      StWrite: begin
        stall         = 1'b1;
        inputData     = buf_q;
        fetchData     = buf_q;
        in_tag        = tag_q;
        inp_viv       = 1'b1;
        regWrite_set0 = !victim_q;
        regWrite_set1 = victim_q;
        vbit_d[idx_q] = !vbit_q[idx_q];
        line_d        = buf_q;
        state_d       = StDone;
      end
      StDone: begin
        fill_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      line_addr_q <= '0;
      idx_q       <= '0;
      tag_q       <= '0;
      victim_q    <= 1'b0;
      vbit_q      <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      idx_q       <= idx_d;
      tag_q       <= tag_d;
      victim_q    <= victim_d;
      vbit_q      <= vbit_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      line_q      <= line_d;
    end
  end

`ifdef MISS_CNT_EN
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (miss_start) miss_cnt_d = miss_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) miss_cnt_q <= '0;
    else        miss_cnt_q <= miss_cnt_d;
  end

  assign miss_count = miss_cnt_q;
`else
  assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cache_miss_fill.sv
// Bench for cache_miss_fill: timeline model of each fill checked every cycle, plus literal pins.
module tb_cache_miss_fill;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic [31:0]  pcOut;
  logic         hit;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;
  logic         stall;
  logic         regWrite_set0;
  logic         regWrite_set1;
  logic         inp_viv;
  logic [23:0]  in_tag;
  logic [255:0] inputData;
  logic [255:0] fetchData;
  logic         fill_valid;
  logic [15:0]  miss_count;

  cache_miss_fill dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .pcOut        (pcOut),
    .hit          (hit),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .stall        (stall),
    .regWrite_set0(regWrite_set0),
    .regWrite_set1(regWrite_set1),
    .inp_viv      (inp_viv),
    .in_tag       (in_tag),
    .inputData    (inputData),
    .fetchData    (fetchData),
    .fill_valid   (fill_valid),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: cycle windows of the current fill, derived from the miss cycle and stimulus timing.
  int           t_miss = -100, t_gnt = -100, t_fill = -100, t_write = -100, t_done = -100;
  logic [255:0] exp_line = '0, prev_line = '0;
  logic [31:0]  exp_addr = '0;
  logic [23:0]  exp_tag = '0;
  logic         exp_way = 1'b0;
  logic [7:0]   vbit_m = '0;
  int           n_miss = 0;

  // Observations of DUT behaviour, compared against literals.
  int           obs_fill = -1;
  int           obs_wr_cnt = 0;
  logic         obs_way = 1'b0;
  logic [31:0]  obs_addr = '0;
  logic [23:0]  obs_tag = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  int           cc;
  logic [255:0] ef;
  logic [15:0]  ecnt;
  always @(negedge clk) begin
    cc = cyc;
    if (!reset) begin
      chk("rst_ctrl", {stall, mem_req, regWrite_set0, regWrite_set1, inp_viv, fill_valid}, '0);
      chk("rst_fetchData", fetchData, '0);
      chk("rst_inputData", inputData, '0);
      chk("rst_miss_count", miss_count, '0);
    end else begin
      chk("stall", stall, cc > t_miss && cc <= t_write);
      chk("mem_req", mem_req, cc > t_miss && cc <= t_gnt);
      if (cc > t_miss && cc <= t_gnt) chk("mem_addr", mem_addr, exp_addr);
      chk("wr_set0", regWrite_set0, cc == t_write && !exp_way);
      chk("wr_set1", regWrite_set1, cc == t_write && exp_way);
      chk("inp_viv", inp_viv, cc == t_write);
      if (cc == t_write) chk("in_tag", in_tag, exp_tag);
      chk("fill_valid", fill_valid, cc == t_done);
      ef = (cc >= t_write) ? exp_line : prev_line;
      chk("fetchData", fetchData, ef);
      chk("inputData", inputData, ef);
`ifdef MISS_CNT_EN
      ecnt = (cc > t_miss) ? 16'(n_miss) : 16'(n_miss - 1);
`else
      ecnt = 16'h0000;
`endif
      chk("miss_count", miss_count, ecnt);
    end
    if (fill_valid) obs_fill = cc;
    if (regWrite_set0) begin obs_way = 1'b0; obs_wr_cnt++; end
    if (regWrite_set1) begin obs_way = 1'b1; obs_wr_cnt++; end
    if (mem_req) obs_addr = mem_addr;
    if (inp_viv) obs_tag = in_tag;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    t_miss = -100; t_gnt = -100; t_fill = -100; t_write = -100; t_done = -100;
    exp_line = '0; prev_line = '0; vbit_m = '0; n_miss = 0;
  endtask

  // One miss; abort_at < 8 asserts reset in the cycle that beat would arrive.
  task automatic run_miss(input logic [31:0] pc, input int gnt_wait, input int gap,
                          input logic [31:0] base, input int abort_at);
    int k, b, idx;
    logic beat;
    idx = int'(pc[7:5]);
    prev_line = exp_line;
    for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = base + 32'(i);
    exp_addr = {pc[31:5], 5'b0};
    exp_tag = pc[31:8];
    exp_way = vbit_m[idx];
    obs_wr_cnt = 0;
    n_miss++;
    t_miss = cyc;
    t_gnt = t_miss + 1 + gnt_wait;
    t_fill = t_gnt + 1;
    t_write = t_fill + 7 * (gap + 1) + 1;
    t_done = t_write + 1;
    req_valid = 1'b1; hit = 1'b0; pcOut = pc; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    tick();
    while (cyc <= t_done) begin
      k = cyc - t_fill;
      b = k / (gap + 1);
      beat = (k >= 0) && (k % (gap + 1) == 0) && (b < 8);
      if (beat && b == abort_at) begin
        mem_rvalid = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("abort_ctrl", {stall, mem_req, regWrite_set0, regWrite_set1, fill_valid}, '0);
        chk("abort_fetchData", fetchData, '0);
        req_valid = 1'b0; hit = 1'b0; mem_gnt = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        return;
      end
      // Front-end noise while busy must be ignored.
      req_valid = 1'($urandom_range(0, 1));
      hit = 1'($urandom_range(0, 1));
      pcOut = $urandom;
      mem_gnt = (cyc == t_gnt);
      if (beat) begin
        mem_rvalid = 1'b1;
        mem_rdata = base + 32'(b);
      end else begin
        mem_rvalid = (cyc < t_fill || cyc >= t_write) ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = $urandom;
      end
      tick();
    end
    vbit_m[idx] = ~vbit_m[idx];
    req_valid = 1'b0; hit = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; pcOut = '0; hit = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick();
    tick();
    chk("reset_mem_req", mem_req, 0);
    chk("reset_stall", stall, 0);
    reset = 1'b1;
    tick();

    req_valid = 1'b1; hit = 1'b1; pcOut = 32'h0000_1040;
    repeat (5) tick();
    chk("hit_no_req", {stall, mem_req}, 0);
    req_valid = 1'b0; hit = 1'b0;
    tick();

    run_miss(32'h1234_5A64, 2, 0, 32'h0, 8);
    chk("m1_latency", 32'(obs_fill - t_miss), 13);
    chk("m1_addr", obs_addr, 32'h1234_5A60);
    chk("m1_tag", obs_tag, 24'h12_345A);
    chk("m1_way", obs_way, 0);
    chk("m1_writes", obs_wr_cnt, 1);
    chk("m1_beat0", fetchData[31:0], 32'h0);
    chk("m1_beat7", fetchData[255:224], 32'h7);

    run_miss(32'hABCD_E170, 1, 0, 32'hB000_0000, 8);
    chk("m2_way", obs_way, 1);
    chk("m2_latency", 32'(obs_fill - t_miss), 12);

    run_miss(32'h0000_0064, 0, 0, 32'hC000_0000, 8);
    chk("m3_way", obs_way, 0);
    chk("m3_latency", 32'(obs_fill - t_miss), 11);

    run_miss(32'h0000_10A0, 2, 1, 32'hD000_0000, 8);
    chk("gap_latency", 32'(obs_fill - t_miss), 20);
    chk("gap_way", obs_way, 0);
    chk("gap_beat3", fetchData[127:96], 32'hD000_0003);

    run_miss(32'h1234_5A64, 1, 0, 32'hE000_0000, 5);
    chk("abort_no_write", obs_wr_cnt, 0);

    run_miss(32'h1234_5A64, 0, 0, 32'hF000_0000, 8);
    chk("post_abort_way", obs_way, 0);
    chk("post_abort_beat0", fetchData[31:0], 32'hF000_0000);
    chk("post_abort_beat7", fetchData[255:224], 32'hF000_0007);

    run_miss(32'h1234_5A70, 0, 0, 32'h1100_0000, 8);
    chk("m6_way", obs_way, 1);
    run_miss(32'h0000_0020, 1, 0, 32'h2200_0000, 8);
    chk("m7_way", obs_way, 0);

    req_valid = 1'b1; hit = 1'b1; pcOut = 32'h0000_2000;
    repeat (5) tick();
    req_valid = 1'b0; hit = 1'b0;
    tick();
`ifdef MISS_CNT_EN
    chk("miss_count_final", miss_count, 16'd3);
`else
    chk("miss_count_final", miss_count, 16'd0);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
